// File: rtl/io_status_arbiter.sv
// io_status_arbiter: two-requester status-pad arbiter with a code FIFO and a
// minimum-hold replay engine, so a slow pad monitor sees every code in order.
module io_status_arbiter #(
    parameter int unsigned CODE_W      = 5,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     core_valid,
    input  logic [CODE_W-1:0]        core_code,
    output logic                     core_ready,
    input  logic                     la_valid,
    input  logic [CODE_W-1:0]        la_code,
    output logic                     la_ready,
    output logic [CODE_W-1:0]        status_out,
    output logic                     status_oeb,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Elaboration-time guard on the parameter ranges the pointer logic relies on.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("io_status_arbiter: DEPTH must be a power of two >= 2");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("io_status_arbiter: HOLD_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    hold_cnt;

    logic [CODE_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    // Set when LA should win the next tie (last accept went to core).
    logic                rr_pref_la;

    logic                full;
    logic                empty;
    logic                grant_core;
    logic                grant_la;
    logic                push;
    logic                pop;
    logic [CODE_W-1:0]   push_code;
    logic [CODE_W-1:0]   head_code;

    // Occupancy flags come from the registered level, so a same-cycle pop
    // never frees a slot until the following cycle.
    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);

    // Round-robin grant among valid requesters while a slot is free.
    always_comb begin
        grant_core = 1'b0;
        grant_la   = 1'b0;
        if (!full) begin
            if (core_valid && la_valid) begin
                grant_la   = rr_pref_la;
                grant_core = !rr_pref_la;
            end else begin
                grant_core = core_valid;
                grant_la   = la_valid;
            end
        end
    end

    assign core_ready = grant_core;
    assign la_ready   = grant_la;
    assign push       = grant_core || grant_la;
    assign push_code  = grant_core ? core_code : la_code;
    assign head_code  = mem[rd_ptr];

    // The replay engine takes the head when idle, or when the hold window ends.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if (hold_cnt == '0) begin
                pop = 1'b1;
            end
        end
    end

    assign busy = (!empty) || (state != IDLE);

    // Round-robin pointer moves only on an actual accept.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rr_pref_la <= 1'b0;
        end else if (push) begin
            rr_pref_la <= grant_core;
        end
    end

    // FIFO storage; contents need no reset since pointers and level are cleared.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= push_code;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Replay FSM: drives each popped code for at least HOLD_CYCLES cycles.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            status_out <= '1;
            status_oeb <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        status_out <= head_code;
                        status_oeb <= 1'b0;
                        hold_cnt   <= CNT_LOAD;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end else if (pop) begin
                        status_out <= head_code;
                        hold_cnt   <= CNT_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_status_arbiter.sv
// Bench for io_status_arbiter: scoreboarded pad replay plus arbitration,
// full-FIFO, reset and single-cycle-hold scenarios.
module tb_io_status_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       core_valid = 1'b0;
    logic [4:0] core_code  = '0;
    logic       la_valid   = 1'b0;
    logic [4:0] la_code    = '0;
    logic       core_ready;
    logic       la_ready;
    logic [4:0] status_out;
    logic       status_oeb;
    logic       busy;
    logic [2:0] level;

    logic       f_core_valid = 1'b0;
    logic [4:0] f_core_code  = '0;
    logic       f_la_valid   = 1'b0;
    logic [4:0] f_la_code    = '0;
    logic       f_core_ready;
    logic       f_la_ready;
    logic [4:0] f_status_out;
    logic       f_status_oeb;
    logic       f_busy;
    logic [2:0] f_level;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [4:0] code;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] shown = 5'h1f;
    bit         track = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    io_status_arbiter #(.CODE_W(5), .DEPTH(4), .HOLD_CYCLES(16)) u_dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .core_valid (core_valid),
        .core_code  (core_code),
        .core_ready (core_ready),
        .la_valid   (la_valid),
        .la_code    (la_code),
        .la_ready   (la_ready),
        .status_out (status_out),
        .status_oeb (status_oeb),
        .busy       (busy),
        .level      (level)
    );

    io_status_arbiter #(.CODE_W(5), .DEPTH(4), .HOLD_CYCLES(1)) u_fast (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .core_valid (f_core_valid),
        .core_code  (f_core_code),
        .core_ready (f_core_ready),
        .la_valid   (f_la_valid),
        .la_code    (f_la_code),
        .la_ready   (f_la_ready),
        .status_out (f_status_out),
        .status_oeb (f_status_oeb),
        .busy       (f_busy),
        .level      (f_level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Scoreboard: retire each expected code at its due cycle, then require the
    // pads to show the most recently retired code every cycle.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            shown = sb[0].code;
            sb.delete(0);
        end
        if (track) check("disp", 32'(status_out), 32'(shown));
    end

    int         n0;
    int         f0;
    int         m0;
    int         k;
    int         exp_lvl;
    bit         v;
    bit         acc;
    bit         pop_e;
    string      tag;
    logic [4:0] f_tab  [0:6];
    logic [4:0] f_push [0:2];

    initial begin
        f_tab  = '{5'h1f, 5'h1f, 5'h03, 5'h0c, 5'h11, 5'h11, 5'h11};
        f_push = '{5'h03, 5'h0c, 5'h11};

        // Reset, then idle.
        rst = 1'b1;
        repeat (3) tick();
        rst   = 1'b0;
        track = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            settle();
            check("rst_oeb",    32'(status_oeb), 32'd1);
            check("rst_busy",   32'(busy),       32'd0);
            check("rst_level",  32'(level),      32'd0);
            check("rst_crdy",   32'(core_ready), 32'd0);
            check("rst_lrdy",   32'(la_ready),   32'd0);
            check("rst_status", 32'(status_out), 32'h1f);
        end

        // Core pushes three codes back to back.
        tick();
        n0 = cyc;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            core_valid = 1'b1;
            core_code  = (i == 0) ? 5'h00 : ((i == 1) ? 5'h02 : 5'h01);
            sb.push_back('{core_code, n0 + 2 + 16 * i});
            settle();
            check("s2_crdy", 32'(core_ready), 32'd1);
            check("s2_oeb",  32'(status_oeb), (cyc >= n0 + 2) ? 32'd0 : 32'd1);
            check("s2_busy", 32'(busy),       (cyc >= n0 + 1 && cyc < n0 + 50) ? 32'd1 : 32'd0);
        end
        while (cyc < n0 + 52) begin
            tick();
            core_valid = 1'b0;
            settle();
            check("s2_oeb",  32'(status_oeb), (cyc >= n0 + 2) ? 32'd0 : 32'd1);
            check("s2_busy", 32'(busy),       (cyc >= n0 + 1 && cyc < n0 + 50) ? 32'd1 : 32'd0);
            check("s2_crdy", 32'(core_ready), 32'd0);
        end
        check("s2_status_last", 32'(status_out), 32'h01);
        check("s2_sb_drain",    32'(sb.size()),  32'd0);

        // Single-cycle hold build: three codes on consecutive cycles.
        tick();
        f0 = cyc;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            f_core_valid = (i < 3);
            f_core_code  = (i < 3) ? f_push[i] : 5'h00;
            settle();
            if (i < 3) check("fast_rdy", 32'(f_core_ready), 32'd1);
            check("fast_status", 32'(f_status_out), 32'(f_tab[i]));
            check("fast_busy",   32'(f_busy), (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
        end

        // Both requesters saturate the FIFO; then reset mid-hold with 3 queued.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        shown = 5'h1f;
        settle();
        tick();
        m0      = cyc;
        k       = 0;
        exp_lvl = 0;
        for (int c = m0; c <= m0 + 52; c++) begin
            if (c != m0) tick();
            v          = (c <= m0 + 34);
            core_valid = v;
            la_valid   = v;
            core_code  = 5'h0a;
            la_code    = 5'h15;
            acc   = v && ((c <= m0 + 4) || (c >= m0 + 18 && ((c - m0 - 18) % 16) == 0));
            pop_e = (c >= m0 + 1) && (((c - m0 - 1) % 16) == 0);
            if (acc) sb.push_back('{((k % 2) == 0) ? 5'h0a : 5'h15, m0 + 2 + 16 * k});
            if (c == m0 + 52) rst = 1'b1;
            settle();
            if (c == m0 + 17)      tag = "full_pop";
            else if (c == m0 + 18) tag = "full_pop_next";
            else                   tag = "arb";
            check({tag, "_crdy"}, 32'(core_ready), 32'(acc && ((k % 2) == 0)));
            check({tag, "_lrdy"}, 32'(la_ready),   32'(acc && ((k % 2) == 1)));
            check({tag, "_level"}, 32'(level),     32'(exp_lvl));
            check("level_max", 32'(level <= 3'd4), 32'd1);
            if (acc) k++;
            exp_lvl = exp_lvl + int'(acc) - int'(pop_e);
        end
        check("pre_rst_level", 32'(exp_lvl), 32'd3);

        tick();
        rst = 1'b0;
        sb.delete();
        shown = 5'h1f;
        settle();
        check("pulse_status", 32'(status_out), 32'h1f);
        check("pulse_oeb",    32'(status_oeb), 32'd1);
        check("pulse_busy",   32'(busy),       32'd0);
        check("pulse_level",  32'(level),      32'd0);
        check("pulse_crdy",   32'(core_ready), 32'd0);
        check("pulse_lrdy",   32'(la_ready),   32'd0);
        for (int i = 0; i < 60; i++) begin
            tick();
            settle();
            check("post_rst_oeb",  32'(status_oeb), 32'd1);
            check("post_rst_busy", 32'(busy),       32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_status_arbiter.md
Name: io_status_arbiter

Overview:
- Shares the user-project status pads (the mprj_io status field, e.g. bits [24:20]) between two requesters: the core's status/MMIO writer and the logic-analyzer (LA) path.
- Accepted status codes are buffered in a small FIFO.
- Each code is replayed on the pads for a guaranteed minimum number of cycles, so a slow external monitor sees every code in order, with none merged or lost.
- Sits between the core/LA wrappers and the mprj_io output/oeb mux in the user project wrapper.

Parameters:
- CODE_W, 5, width of one status code.
- DEPTH, 4, FIFO entries. Must be a power of two, at least 2.
- HOLD_CYCLES, 16, minimum cycles each code stays on status_out. Must be at least 1.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- core_valid  in  1  core offers core_code this cycle.
- core_code  in  CODE_W  core status code.
- core_ready  out  1  core_code accepted this cycle (valid and ready both high).
- la_valid  in  1  LA offers la_code this cycle.
- la_code  in  CODE_W  LA status code.
- la_ready  out  1  la_code accepted this cycle.
- status_out  out  CODE_W  code driven to the pads.
- status_oeb  out  1  pad output-enable, active-low (0 = driving).
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (wb_rst_i high at a rising edge), regardless of state:
  - status_out = all ones; status_oeb = 1; busy = 0; level = 0.
  - FIFO emptied; FSM to IDLE; hold counter 0.
  - Round-robin pointer set to favour core.
  - Reset mid-HOLD discards the held code and all queued codes.
- Arbitration (combinational ready, one accept per cycle at most):
  - If FIFO full at cycle start, core_ready = la_ready = 0. A pop in the same cycle does not open a slot until the next cycle.
  - Not full, one valid: that requester gets ready = 1.
  - Not full, both valid: the requester not granted last time wins. The pointer updates only on an actual accept.
  - ready is never asserted without the matching valid.
- FIFO:
  - Push on accept. Pop by the FSM.
  - Pointers wrap modulo DEPTH. level = pushes minus pops, range 0..DEPTH.
  - Simultaneous push and pop with level between 1 and DEPTH-1: level unchanged.
- Output FSM:
  - IDLE: if level > 0, pop the head and go to HOLD. status_out takes the popped code one cycle after the pop decision (registered). status_oeb goes to 0 on the first pop and stays 0 until reset. Counter loads HOLD_CYCLES-1.
  - HOLD: counter decrements each cycle.
    - At counter = 0 with level > 0: pop the next code directly, reload the counter, stay in HOLD. The next code appears exactly HOLD_CYCLES cycles after the previous one.
    - At counter = 0 with level = 0: go to IDLE. status_out keeps the last code indefinitely.
  - A code equal to the currently displayed code is still held a full HOLD_CYCLES. No suppression of duplicates.
- Latency, empty FIFO with accept at cycle N: pop decision at N+1, status_out valid at N+2.
- busy = (level != 0) OR (state != IDLE).

Test Plan:
- Reset then idle 20 cycles: status_out = 5'b11111, status_oeb = 1, busy = 0, level = 0, both readies 0.
- Core pushes 5'b00000, then 5'b00010, then 5'b00001 on consecutive cycles:
  - status_out shows 00000 from cycle N+2, 00010 from N+18, 00001 from N+34.
  - status_oeb = 0 from N+2 onward.
  - busy drops at N+50.
- core_valid and la_valid both held high with distinct codes:
  - Accepts alternate core, LA, core, LA.
  - Both readies drop once level = 4.
  - A ready reasserts one cycle after each pop.
- FIFO full with a pop in the same cycle: no accept that cycle; accept on the next cycle; level never exceeds 4.
- wb_rst_i pulsed for one cycle mid-HOLD with 3 codes queued: the next cycle shows the full reset state, and none of the queued codes ever appear.
- HOLD_CYCLES = 1 build, 3 codes pushed: codes appear on 3 consecutive cycles, with no gap cycles.
